knap_search_ctrl: RTL and testbench

//   Exhaustive-search sequencer for a combinational knapsack feasibility checker
//   (one select bit per item in; a single valid out). Steps through every item

---
 rtl/knap_search_ctrl.sv | 132 +++++++++++++
 tb/tb_knap_search_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/knap_search_ctrl.sv
// Exhaustive subset sequencer for a combinational knapsack feasibility checker.
// Walks every item subset once, streams feasible ones over valid/ready and counts them.
module knap_search_ctrl #(
    parameter int unsigned N_ITEMS       = 21,
    parameter int unsigned STOP_ON_FIRST = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic [N_ITEMS-1:0] items_o,
    input  logic               valid_i,
    output logic               sol_valid,
    input  logic               sol_ready,
    output logic [N_ITEMS-1:0] sol_data,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [N_ITEMS:0]   sol_count
);

    localparam int unsigned CNT_W = N_ITEMS + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [N_ITEMS-1:0] ALL_ONES = '1;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [N_ITEMS-1:0] items_nxt;
    logic [N_ITEMS-1:0] sol_data_nxt;
    logic               sol_valid_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               aborted_nxt;
    logic [N_ITEMS:0]   sol_count_nxt;
    logic               slot_free;
    logic               stop_hit;

    // items_o doubles as the candidate register; it is only advanced when the output slot is free
    assign slot_free = !sol_valid || sol_ready;
    assign stop_hit  = (STOP_ON_FIRST != 0) && valid_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        items_nxt     = items_o;
        sol_data_nxt  = sol_data;
        sol_valid_nxt = sol_valid;
        aborted_nxt   = aborted;
        sol_count_nxt = sol_count;

        case (state)
            S_IDLE: begin
                if (start) begin
                    items_nxt     = '0;
                    sol_count_nxt = '0;
                    aborted_nxt   = 1'b0;
                    state_nxt     = S_SCAN;
                end
            end
            S_SCAN: begin
                // abort wins over a same-cycle hit: the hit is neither counted nor emitted
                if (abort) begin
                    sol_valid_nxt = 1'b0;
                    aborted_nxt   = 1'b1;
                    state_nxt     = S_DONE;
                end else if (slot_free) begin
                    if (valid_i) begin
                        sol_data_nxt  = items_o;
                        sol_valid_nxt = 1'b1;
                        sol_count_nxt = sol_count + CNT_W'(1);
                    end else begin
                        sol_valid_nxt = 1'b0;
                    end
                    if (items_o == ALL_ONES || stop_hit) begin
                        state_nxt = S_FLUSH;
                    end else begin
                        items_nxt = items_o + N_ITEMS'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (abort) begin
                    sol_valid_nxt = 1'b0;
                    aborted_nxt   = 1'b1;
                    state_nxt     = S_DONE;
                end else if (slot_free) begin
                    sol_valid_nxt = 1'b0;
                    state_nxt     = S_DONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        done_nxt = (state_nxt == S_DONE);
        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            items_o   <= '0;
            sol_data  <= '0;
            sol_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            sol_count <= '0;
        end else begin
            items_o   <= items_nxt;
            sol_data  <= sol_data_nxt;
            sol_valid <= sol_valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            aborted   <= aborted_nxt;
            sol_count <= sol_count_nxt;
        end
    end

endmodule

// File: tb/tb_knap_search_ctrl.sv
// Directed bench for knap_search_ctrl with N_ITEMS=4 and a behavioural feasibility table.
// u0 runs full scans, u1 runs with STOP_ON_FIRST=1.
module tb_knap_search_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, abort0, ready0, valid0;
    logic [3:0]  items0, data0;
    logic        sv0, busy0, done0, ab0;
    logic [4:0]  cnt0;
    logic [15:0] feas0;

    logic        start1, abort1, ready1, valid1;
    logic [3:0]  items1, data1;
    logic        sv1, busy1, done1, ab1;
    logic [4:0]  cnt1;
    logic [15:0] feas1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign valid0 = feas0[items0];
    assign valid1 = feas1[items1];

    knap_search_ctrl #(.N_ITEMS(4), .STOP_ON_FIRST(0)) u0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .items_o(items0), .valid_i(valid0), .sol_valid(sv0), .sol_ready(ready0),
        .sol_data(data0), .busy(busy0), .done(done0), .aborted(ab0), .sol_count(cnt0)
    );

    knap_search_ctrl #(.N_ITEMS(4), .STOP_ON_FIRST(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .items_o(items1), .valid_i(valid1), .sol_valid(sv1), .sol_ready(ready1),
        .sol_data(data1), .busy(busy1), .done(done1), .aborted(ab1), .sol_count(cnt1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset(input string tag);
        rst = 1'b1;
        tick();
        n_checks++;
        if ({items0, sv0, data0, busy0, done0, ab0, cnt0} !== 17'd0) begin
            n_fail++;
            $display("FAIL %s_u0 got=%h required=0", tag, {items0, sv0, data0, busy0, done0, ab0, cnt0});
        end
        n_checks++;
        if ({items1, sv1, data1, busy1, done1, ab1, cnt1} !== 17'd0) begin
            n_fail++;
            $display("FAIL %s_u1 got=%h required=0", tag, {items1, sv1, data1, busy1, done1, ab1, cnt1});
        end
        rst = 1'b0;
    endtask

    // feasible {5,15}, consumer always ready
    task automatic test_full_scan(input string tag);
        logic [3:0] ei;
        logic       esv, edn, eby;
        feas0 = 16'h8020; ready0 = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n_checks++;
        if (busy0 !== 1'b1 || items0 !== 4'd0) begin
            n_fail++;
            $display("FAIL %s_start busy=%b items=%0d required busy=1 items=0", tag, busy0, items0);
        end
        for (int k = 1; k <= 18; k++) begin
            tick();
            ei  = (k <= 15) ? 4'(k) : 4'd15;
            esv = (k == 6) || (k == 16);
            edn = (k == 17);
            eby = (k <= 17);
            n_checks++;
            if ({items0, sv0, done0, busy0} !== {ei, esv, edn, eby}) begin
                n_fail++;
                $display("FAIL %s_edge%0d items/valid/done/busy got=%h/%b/%b/%b required=%h/%b/%b/%b",
                         tag, k, items0, sv0, done0, busy0, ei, esv, edn, eby);
            end
            if (esv) begin
                n_checks++;
                if (data0 !== ((k == 6) ? 4'h5 : 4'hF)) begin
                    n_fail++;
                    $display("FAIL %s_data_edge%0d got=%h required=%h", tag, k, data0, (k == 6) ? 4'h5 : 4'hF);
                end
            end
        end
        n_checks++;
        if (cnt0 !== 5'd2 || ab0 !== 1'b0 || data0 !== 4'hF) begin
            n_fail++;
            $display("FAIL %s_final count=%0d aborted=%b data=%h required 2/0/f", tag, cnt0, ab0, data0);
        end
    endtask

    // consumer not ready until it is sampled ready at edge 12
    task automatic test_backpressure();
        logic [3:0] ei;
        logic       esv, edn, eby;
        feas0 = 16'h8020; ready0 = 1'b0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 1; k <= 23; k++) begin
            tick();
            ei  = (k <= 6) ? 4'(k) : (k <= 11) ? 4'd6 : (k <= 20) ? 4'(k - 5) : 4'd15;
            esv = ((k >= 6) && (k <= 11)) || (k == 21);
            edn = (k == 22);
            eby = (k <= 22);
            n_checks++;
            if ({items0, sv0, done0, busy0} !== {ei, esv, edn, eby}) begin
                n_fail++;
                $display("FAIL bp_edge%0d items/valid/done/busy got=%h/%b/%b/%b required=%h/%b/%b/%b",
                         k, items0, sv0, done0, busy0, ei, esv, edn, eby);
            end
            if (k >= 6 && k <= 11) begin
                n_checks++;
                if (data0 !== 4'h5) begin
                    n_fail++;
                    $display("FAIL bp_hold_edge%0d data got=%h required=5", k, data0);
                end
            end
            if (k == 11) ready0 = 1'b1;
        end
        n_checks++;
        if (cnt0 !== 5'd2) begin
            n_fail++;
            $display("FAIL bp_count got=%0d required=2", cnt0);
        end
    endtask

    task automatic test_stop_on_first();
        feas1 = 16'h0028; ready1 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_checks++;
            if (items1 > 4'd3 || sv1 !== (k == 4) || done1 !== (k == 5)) begin
                n_fail++;
                $display("FAIL sof_edge%0d items=%0d valid=%b done=%b required items<=3 valid=%b done=%b",
                         k, items1, sv1, done1, k == 4, k == 5);
            end
        end
        n_checks++;
        if (cnt1 !== 5'd1 || data1 !== 4'h3 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL sof_final count=%0d data=%h busy=%b required 1/3/0", cnt1, data1, busy1);
        end
    endtask

    // abort with a pending solution; a start while busy is ignored
    task automatic test_abort_pending();
        feas0 = 16'h8020; ready0 = 1'b0;
        start0 = 1'b1;
        tick();
        tick();
        start0 = 1'b0;
        n_checks++;
        if (items0 !== 4'd1) begin
            n_fail++;
            $display("FAIL abort_busy_start items got=%0d required=1", items0);
        end
        for (int k = 2; k <= 7; k++) tick();
        n_checks++;
        if (sv0 !== 1'b1 || items0 !== 4'd6) begin
            n_fail++;
            $display("FAIL abort_pre valid=%b items=%0d required 1/6", sv0, items0);
        end
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
        n_checks++;
        if ({sv0, ab0, done0, busy0, cnt0} !== {4'b0111, 5'd1}) begin
            n_fail++;
            $display("FAIL abort_edge valid/aborted/done/busy/count got=%b%b%b%b/%0d required 0111/1",
                     sv0, ab0, done0, busy0, cnt0);
        end
        tick();
        n_checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || ab0 !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_idle busy=%b done=%b aborted=%b required 0/0/1", busy0, done0, ab0);
        end
        ready0 = 1'b1;
    endtask

    // abort in the same cycle as a hit on cand 2
    task automatic test_abort_beats_hit();
        feas0 = 16'h0004; ready0 = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        tick();
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
        n_checks++;
        if (sv0 !== 1'b0 || cnt0 !== 5'd0 || ab0 !== 1'b1 || done0 !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_hit valid=%b count=%0d aborted=%b done=%b required 0/0/1/1", sv0, cnt0, ab0, done0);
        end
        tick();
        abort0 = 1'b1;
        tick();
        tick();
        abort0 = 1'b0;
        n_checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_in_idle busy=%b done=%b required 0/0", busy0, done0);
        end
    endtask

    task automatic test_reset_mid_scan();
        feas0 = 16'h8020; ready0 = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 1; k <= 8; k++) tick();
        test_reset("reset_mid_scan");
        test_full_scan("rescan");
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0; abort0 = 1'b0; ready0 = 1'b1; feas0 = '0;
        start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1; feas1 = '0;
        tick();
        test_reset("reset");
        test_full_scan("full");
        test_backpressure();
        test_stop_on_first();
        test_abort_pending();
        test_abort_beats_hit();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
